// File: rtl/cpu_core_pkg.sv
// cpu_core_pkg: shared core widths and writeback requester indices
package cpu_core_pkg;
  localparam int XLEN = 64;
  localparam int REG_AW = 5;
  localparam int NUM_REGS = 32;
  localparam int WB_REQ_ALU = 0;
  localparam int WB_REQ_LSU = 1;
  localparam int WB_REQ_MDU = 2;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from ptr+1 upward
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int IW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);
  logic found;
  int idx;
  always_comb begin
    gnt = '0;
    gnt_idx = ptr;
    found = 1'b0;
    idx = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the regfile write port plus a
// busy scoreboard of outstanding destination writes
module regfile_wb_arbiter import cpu_core_pkg::*; #(
  parameter int NREQ = 3,
  parameter int XLEN = 64,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 w_ena,
  output logic [AW-1:0]        w_addr,
  output logic [XLEN-1:0]      w_data
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  logic [IW-1:0] ptr, gnt_idx;
  logic [AW-1:0] g_addr;
  logic [XLEN-1:0] g_data;
  logic [NUM_REGS-1:0] busy_nxt;
  logic xfer;
  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req(req_valid),
    .ptr(ptr),
    .gnt(req_ready),
    .gnt_idx(gnt_idx)
  );
  assign xfer = |req_valid;
  assign g_addr = req_addr[gnt_idx*AW +: AW];
  assign g_data = req_data[gnt_idx*XLEN +: XLEN];
  // a new issue wins over a same-register commit: the newer producer is outstanding
  always_comb begin
    busy_nxt = busy;
    if (w_ena) busy_nxt[w_addr] = 1'b0;
    if (iss_valid && iss_rd != '0) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= IW'(NREQ - 1);
      w_ena <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
      busy <= '0;
    end else begin
      if (xfer) begin
        ptr <= gnt_idx;
        w_addr <= g_addr;
        w_data <= g_data;
      end
      w_ena <= xfer && g_addr != '0;
      busy <= busy_nxt;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of arbitration, output stage and scoreboard
module tb_regfile_wb_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [2:0] req_valid;
  logic [14:0] req_addr;
  logic [191:0] req_data;
  logic [2:0] req_ready;
  logic iss_valid;
  logic [4:0] iss_rd;
  logic [31:0] busy;
  logic w_ena;
  logic [4:0] w_addr;
  logic [63:0] w_data;
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_g [6];
  logic [4:0] exp_a [6];
  logic [63:0] exp_d [6];

  regfile_wb_arbiter #(.NREQ(3), .XLEN(64), .AW(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_data(req_data), .req_ready(req_ready), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .busy(busy), .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [63:0] d);
    req_addr[i*5 +: 5] = a;
    req_data[i*64 +: 64] = d;
  endtask

  initial begin
    exp_g = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    exp_a = '{5'd2, 5'd3, 5'd1, 5'd2, 5'd3, 5'd1};
    exp_d = '{64'h22, 64'h33, 64'h11, 64'h22, 64'h33, 64'h11};
    // 1: reset with everything active
    rst = 1'b0;
    req_valid = 3'b111;
    req_addr = '0;
    req_data = '0;
    set_req(0, 5'd1, 64'h11);
    set_req(1, 5'd2, 64'h22);
    set_req(2, 5'd3, 64'h33);
    iss_valid = 1'b1;
    iss_rd = 5'd3;
    repeat (2) @(negedge clk);
    chk("rst_w_ena", 64'(w_ena), 64'd0);
    chk("rst_w_addr", 64'(w_addr), 64'd0);
    chk("rst_w_data", w_data, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'b001);
    req_valid = 3'b001;
    set_req(0, 5'd5, 64'hA5);
    iss_valid = 1'b0;
    rst = 1'b1;
    #1 chk("t1_ready", 64'(req_ready), 64'b001);
    @(negedge clk);
    chk("t1_w_ena", 64'(w_ena), 64'd1);
    chk("t1_w_addr", 64'(w_addr), 64'd5);
    chk("t1_w_data", w_data, 64'hA5);
    // 2: round robin, pointer now at req0
    req_valid = 3'b111;
    set_req(0, 5'd1, 64'h11);
    for (int i = 0; i < 6; i++) begin
      #1 chk($sformatf("rr_ready%0d", i), 64'(req_ready), 64'(exp_g[i]));
      @(negedge clk);
      chk($sformatf("rr_w_ena%0d", i), 64'(w_ena), 64'd1);
      chk($sformatf("rr_w_addr%0d", i), 64'(w_addr), 64'(exp_a[i]));
      chk($sformatf("rr_w_data%0d", i), w_data, exp_d[i]);
    end
    // 3: write to x0 accepted but suppressed
    req_valid = 3'b010;
    set_req(1, 5'd0, 64'hFF);
    #1 chk("x0_ready", 64'(req_ready), 64'b010);
    @(negedge clk);
    chk("x0_w_ena", 64'(w_ena), 64'd0);
    chk("x0_busy", 64'(busy), 64'd0);
    req_valid = 3'b111;
    #1 chk("x0_ptr_adv", 64'(req_ready), 64'b100);
    @(negedge clk);
    chk("x0_next_addr", 64'(w_addr), 64'd3);
    req_valid = 3'b000;
    #1 chk("idle_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    chk("idle_w_ena", 64'(w_ena), 64'd0);
    chk("idle_hold_addr", 64'(w_addr), 64'd3);
    chk("idle_hold_data", w_data, 64'h33);
    // 4: scoreboard set then clear on commit
    iss_valid = 1'b1;
    iss_rd = 5'd7;
    @(negedge clk);
    iss_valid = 1'b0;
    chk("sb_set7", 64'(busy), 64'h80);
    req_valid = 3'b001;
    set_req(0, 5'd7, 64'h77);
    @(negedge clk);
    req_valid = 3'b000;
    chk("sb_commit_ena", 64'(w_ena), 64'd1);
    chk("sb_before_clr", 64'(busy), 64'h80);
    @(negedge clk);
    chk("sb_clr7", 64'(busy), 64'd0);
    iss_valid = 1'b1;
    iss_rd = 5'd0;
    @(negedge clk);
    iss_valid = 1'b0;
    chk("sb_x0_never_busy", 64'(busy), 64'd0);
    // 5: set/clear collision, then different registers
    iss_valid = 1'b1;
    iss_rd = 5'd9;
    @(negedge clk);
    iss_valid = 1'b0;
    chk("col_set9", 64'(busy), 64'h200);
    req_valid = 3'b001;
    set_req(0, 5'd9, 64'h99);
    @(negedge clk);
    req_valid = 3'b000;
    chk("col_w_addr", 64'(w_addr), 64'd9);
    iss_valid = 1'b1;
    @(negedge clk);
    iss_valid = 1'b0;
    chk("col_same_stays", 64'(busy), 64'h200);
    req_valid = 3'b001;
    @(negedge clk);
    req_valid = 3'b000;
    chk("col2_w_ena", 64'(w_ena), 64'd1);
    iss_valid = 1'b1;
    iss_rd = 5'd10;
    @(negedge clk);
    iss_valid = 1'b0;
    chk("col_diff_both", 64'(busy), 64'h400);
    // 6: async reset between edges; pointer is at req0, so req1 wins first
    req_valid = 3'b111;
    set_req(0, 5'd1, 64'h11);
    set_req(1, 5'd2, 64'h22);
    @(negedge clk);
    chk("ar_pre_w_ena", 64'(w_ena), 64'd1);
    chk("ar_pre_w_addr", 64'(w_addr), 64'd2);
    #2 rst = 1'b0;
    #1 chk("ar_w_ena", 64'(w_ena), 64'd0);
    chk("ar_busy", 64'(busy), 64'd0);
    chk("ar_ready", 64'(req_ready), 64'b001);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("ar_rel_ready", 64'(req_ready), 64'b001);
    @(negedge clk);
    chk("ar_rel_w_addr", 64'(w_addr), 64'd1);
    chk("ar_rel_w_data", w_data, 64'h11);
    req_valid = 3'b000;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
